// File: rtl/debug_unit.sv
// Host-side debug controller for the 5-stage MIPS core: loads instruction memory from UART bytes,
// gates the core with mips_run (continuous or single-step) and streams the core state back.
module debug_unit #(
  parameter int unsigned LEN        = 32,
  parameter int unsigned NB_REG     = 5,
  parameter int unsigned MEM_WORDS  = 32,
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned MAX_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     rx_data,
  input  logic           rx_done,
  input  logic           tx_done,
  output logic [7:0]     tx_data,
  output logic           tx_start,
  input  logic           halt_flag,
  input  logic [LEN-1:0] pc,
  input  logic [LEN-1:0] reg_data,
  input  logic [LEN-1:0] mem_data,
  output logic           mips_run,
  output logic           debug_flag,
  output logic [LEN-1:0] addr_debug,
  output logic [LEN-1:0] addr_mem_inst,
  output logic [LEN-1:0] ins_to_mem,
  output logic           wea_ram_inst
);

  localparam int unsigned NumRegs  = 1 << NB_REG;
  localparam int unsigned NumWords = 2 + NumRegs + MEM_WORDS;
  localparam int unsigned WordW    = $clog2(NumWords);
  localparam int unsigned WaitW    = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  localparam logic [WordW-1:0] RegBase  = WordW'(2);
  localparam logic [WordW-1:0] MemBase  = WordW'(2 + NumRegs);
  localparam logic [WordW-1:0] LastWord = WordW'(NumWords - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RD_WAIT - 1);
  localparam logic [LEN-1:0]   CycLimit = LEN'(MAX_CYCLES);

  typedef enum logic [3:0] {
    StIdle,
    StLoadCnt,
    StLoadByte,
    StLoadWrite,
    StRun,
    StStep,
    StDumpAddr,
    StDumpRead,
    StDumpSend,
    StDumpWait
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       n_q, n_d;
  logic [LEN-1:0]   idx_q, idx_d;
  logic [1:0]       byte_q, byte_d;
  logic [LEN-1:0]   shift_q, shift_d;
  logic [LEN-1:0]   cycle_q, cycle_d;
  logic [WordW-1:0] word_q, word_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [LEN-1:0]   buf_q, buf_d;
  logic [LEN-1:0]   addr_debug_q, addr_debug_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             run_en;
  logic [LEN-1:0]   rd_word;

  // Source of the word currently being dumped: PC, cycle count, then register file, then memory.
  always_comb begin
    if (word_q == '0) begin
      rd_word = pc;
    end else if (word_q == WordW'(1)) begin
      rd_word = cycle_q;
    end else if (word_q < MemBase) begin
      rd_word = reg_data;
    end else begin
      rd_word = mem_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    byte_d       = byte_q;
    shift_d      = shift_q;
    cycle_d      = cycle_q;
    word_d       = word_q;
    wait_d       = wait_q;
    buf_d        = buf_q;
    addr_debug_d = addr_debug_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    run_en       = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_done) begin
          case (rx_data)
            8'h4C:   state_d = StLoadCnt;
            8'h43:   state_d = StRun;
            8'h53:   state_d = StStep;
            default: state_d = StIdle;
          endcase
        end
      end

      StLoadCnt: begin
        if (rx_done) begin
          if (rx_data == 8'h00) begin
            state_d = StIdle;
          end else begin
            n_d     = rx_data;
            idx_d   = '0;
            cycle_d = '0;
            byte_d  = '0;
            state_d = StLoadByte;
          end
        end
      end

      StLoadByte: begin
        if (rx_done) begin
          shift_d = {shift_q[LEN-9:0], rx_data};
          byte_d  = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            state_d = StLoadWrite;
          end
        end
      end

      StLoadWrite: begin
        idx_d  = idx_q + LEN'(1);
        byte_d = '0;
        state_d = (idx_d == LEN'(n_q)) ? StIdle : StLoadByte;
      end

      StRun: begin
        // Watchdog shares the persistent cycle counter.
        if (!halt_flag && (cycle_q < CycLimit)) begin
          run_en  = 1'b1;
          cycle_d = cycle_q + LEN'(1);
        end else begin
          word_d  = '0;
          state_d = StDumpAddr;
        end
      end

      StStep: begin
        if (!halt_flag) begin
          run_en  = 1'b1;
          cycle_d = cycle_q + LEN'(1);
        end
        word_d  = '0;
        state_d = StDumpAddr;
      end

      StDumpAddr: begin
        if (word_q >= MemBase) begin
          addr_debug_d = LEN'(word_q - MemBase);
        end else if (word_q >= RegBase) begin
          addr_debug_d = LEN'(word_q - RegBase);
        end
        wait_d  = '0;
        state_d = StDumpRead;
      end

      StDumpRead: begin
        if (wait_q == WaitLast) begin
          buf_d   = rd_word;
          byte_d  = '0;
          state_d = StDumpSend;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      StDumpSend: begin
        tx_data_d  = buf_q[LEN-1 -: 8];
        buf_d      = buf_q << 8;
        tx_start_d = 1'b1;
        state_d    = StDumpWait;
      end

      StDumpWait: begin
        if (tx_done) begin
          if (byte_q == 2'd3) begin
            byte_d = '0;
            if (word_q == LastWord) begin
              state_d = StIdle;
            end else begin
              word_d  = word_q + WordW'(1);
              state_d = StDumpAddr;
            end
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = StDumpSend;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      n_q          <= '0;
      idx_q        <= '0;
      byte_q       <= '0;
      shift_q      <= '0;
      cycle_q      <= '0;
      word_q       <= '0;
      wait_q       <= '0;
      buf_q        <= '0;
      addr_debug_q <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      byte_q       <= byte_d;
      shift_q      <= shift_d;
      cycle_q      <= cycle_d;
      word_q       <= word_d;
      wait_q       <= wait_d;
      buf_q        <= buf_d;
      addr_debug_q <= addr_debug_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
    end
  end

  assign mips_run      = run_en;
  assign debug_flag    = ~run_en;
  assign wea_ram_inst  = (state_q == StLoadWrite);
  assign addr_mem_inst = idx_q;
  assign ins_to_mem    = shift_q;
  assign addr_debug    = addr_debug_q;
  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-side debug controller for the 5-stage MIPS core.
- Receives command bytes from the UART receiver and loads programs into instruction memory.
- Gates execution with `mips_run`, either continuous or single-step.
- After a run or step, reads back PC, cycle count, register file and data memory, and streams them as bytes to the UART transmitter.
- It drives the core's debug inputs (`debug_flag`, debug addresses, instruction write port) and consumes its debug outputs.

Parameters:
- LEN, 32, datapath / word width.
- NB_REG, 5, register-file address width (32 registers).
- MEM_WORDS, 32, number of data-memory words dumped.
- RD_WAIT, 2, cycles between applying a debug address and sampling read data.
- MAX_CYCLES, 65535, run-mode watchdog limit.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from UART RX
- rx_done  in  1  1-cycle pulse, rx_data valid
- tx_done  in  1  1-cycle pulse, TX finished previous byte
- tx_data  out  8  byte to UART TX
- tx_start  out  1  1-cycle pulse, send tx_data
- halt_flag  in  1  core halt indication (end of writeback)
- pc  in  LEN  core PC
- reg_data  in  LEN  register-file read data for addr_debug[4:0]
- mem_data  in  LEN  data-memory read data for addr_debug
- mips_run  out  1  core clock enable
- debug_flag  out  1  core debug mode
- addr_debug  out  LEN  register / data-memory debug address
- addr_mem_inst  out  LEN  instruction-memory write address (word index)
- ins_to_mem  out  LEN  instruction word to write
- wea_ram_inst  out  1  instruction-memory write enable

Behaviour:
- Reset (`reset`=0, async): state IDLE; `debug_flag`=1; all other outputs 0; cycle counter 0; word counter 0.
- `debug_flag` = NOT `mips_run` at all times.
- Commands are accepted only in IDLE; other byte values are ignored.
  - 0x4C 'L' -> LOAD_CNT
  - 0x43 'C' -> RUN
  - 0x53 'S' -> STEP
- LOAD_CNT: next rx byte N.
  - N=0 -> IDLE.
  - Otherwise clear word index and cycle counter, then go to LOAD_BYTE.
- LOAD_BYTE: collect 4 bytes MSB-first into a shift register, then go to LOAD_WRITE.
- LOAD_WRITE (1 cycle): `wea_ram_inst`=1, `addr_mem_inst`=index, `ins_to_mem`=word; index++.
  - index==N -> IDLE.
  - Otherwise -> LOAD_BYTE.
- RUN: `mips_run`=1 each cycle; cycle counter++ per enabled cycle.
  - Leave when `halt_flag`=1 is sampled, or counter reaches MAX_CYCLES.
  - On exit: `mips_run`=0 on the next cycle, go to DUMP.
  - If `halt_flag` is already 1 on entry: zero run cycles, straight to DUMP.
- STEP: `mips_run`=1 for exactly one cycle (none if `halt_flag`=1), counter++, then DUMP.
- rx bytes arriving outside IDLE / LOAD states are dropped.
- DUMP sequence, each word sent as 4 bytes MSB-first:
  1. PC
  2. cycle counter (zero-extended to LEN)
  3. registers 0..31
  4. data memory words 0..MEM_WORDS-1
  - Total bytes = 8 + 128 + 4*MEM_WORDS (264 at defaults).
- Read timing: `addr_debug` is set, held RD_WAIT cycles, then `reg_data` / `mem_data` is latched into the send buffer. `addr_debug` holds until latch.
- Register phase: `addr_debug` = {0, reg index}. Memory phase: `addr_debug` = word index.
- TX handshake: `tx_start` pulses 1 cycle with `tx_data` stable. The next byte is not started until `tx_done` is seen. `tx_data` holds until the next `tx_start`.
- After the last byte's `tx_done`: IDLE.
- Cycle counter persists across steps and runs; it clears only on 'L' with N>0, or on reset.
- Reset mid-load / mid-dump: immediate abort to reset state; partial words are discarded and no write is issued.
- Simultaneous `rx_done` and state exit: the byte is evaluated in the current state only.

Test Plan:
- Reset asserted -> `debug_flag`=1, `mips_run`=0, `tx_start`=0, `wea_ram_inst`=0.
- Send 0x4C, 0x02, 0x20,0x01,0x00,0x05, 0xFF,0xFF,0xFF,0xFF:
  - two 1-cycle `wea_ram_inst` pulses: addr 0 data 0x20010005, then addr 1 data 0xFFFFFFFF;
  - FSM returns to IDLE.
- Send 0x53 with `halt_flag`=0, pc model 4:
  - exactly one `mips_run` cycle;
  - 264 `tx_start` pulses, first four 0x00,0x00,0x00,0x04, next four 0x00,0x00,0x00,0x01.
- Send 0x43 with the model raising `halt_flag` after 10 enabled cycles:
  - `mips_run` high 10 cycles;
  - cycle field = 0x0000000B (after the prior step);
  - reg 1 bytes match the model value 0x00000005.
- `tx_done` delayed 50 cycles per byte -> no `tx_start` before the corresponding `tx_done`; byte order unchanged.
- Reset asserted after 2 bytes of a load word -> no write is issued; a subsequent 'L' 0x01 + 4 bytes writes at addr 0.
